// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer:
//   - FSM state encoding (IDLE, FETCH_LO, FETCH_HI, DONE)
//   - default program-counter width
//   - default memory-wait timeout in cycles
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int PC_WIDTH_DEF = 16;
    localparam int TIMEOUT_DEF  = 15;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FETCH_LO = 2'd1;
    localparam logic [1:0] ST_FETCH_HI = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/fetch_watchdog.sv
// ----------------------------------------------------------------------------
// fetch_watchdog
// Counts the cycles a fetch spends waiting for memory and flags the cycle in
// which the wait count reaches TIMEOUT, so the sequencer can abandon the
// fetch on that clock edge.
//
// Ports:
//   Clock    in   system clock
//   Reset    in   synchronous active-high reset
//   Clear    in   zero the count (sequencer not waiting in a fetch state)
//   Waiting  in   sequencer is in a fetch state with MemReady low
//   Expired  out  this waiting cycle is the TIMEOUT-th one
// ----------------------------------------------------------------------------
module fetch_watchdog
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    input  logic Waiting,
    output logic Expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || Clear)
            count <= '0;
        else if (Waiting)
            count <= count + 1'b1;
    end

    // The count holds the number of wait cycles already elapsed; the current
    // cycle is the TIMEOUT-th when TIMEOUT-1 have gone before it.
    assign Expired = Waiting && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_fetch_sequencer
// Fetches one 16-bit instruction as two byte reads (low byte at PC, high byte
// at PC+1), strobing each byte into the instruction register and advancing
// the PC modulo 2^PC_WIDTH.
//
// Optional feature: define FETCH_TIMEOUT_EN to abandon a fetch after TIMEOUT
// cycles without MemReady (Error pulse, PC restored to its value at Start).
// Without it the sequencer waits indefinitely and Error is tied low.
//
// Ports:
//   Clock     in   system clock
//   Reset     in   synchronous active-high reset
//   Start     in   request one instruction fetch (IDLE only)
//   PCLoad    in   load PC from PCIn (IDLE only, wins over Start)
//   PCIn      in   new PC value
//   MemData   in   byte returned by memory
//   MemReady  in   MemData valid this cycle
//   MemRead   out  memory read request
//   MemAddr   out  read address
//   IRData    out  byte for the instruction register
//   IRWrite   out  instruction-register write strobe
//   IRLH      out  half select (0 = [7:0], 1 = [15:8])
//   PCOut     out  current PC
//   Busy      out  fetch in progress
//   Done      out  one-cycle fetch-complete pulse
//   Error     out  one-cycle timeout pulse
//
// Timing: Start in cycle 1, FETCH_LO in cycle 2, FETCH_HI in cycle 3, Done in
// cycle 4 when MemReady is held high. Each IRWrite strobe appears in the
// cycle after its byte was accepted.
// ----------------------------------------------------------------------------
module instruction_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                PCLoad,
    input  logic [PC_WIDTH-1:0] PCIn,
    input  logic [7:0]          MemData,
    input  logic                MemReady,
    output logic                MemRead,
    output logic [PC_WIDTH-1:0] MemAddr,
    output logic [7:0]          IRData,
    output logic                IRWrite,
    output logic                IRLH,
    output logic [PC_WIDTH-1:0] PCOut,
    output logic                Busy,
    output logic                Done,
    output logic                Error
);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc;
    logic [7:0]          ir_data;
    logic                ir_write;
    logic                ir_lh;
    logic                fetching;
    logic                timeout_hit;
    logic [PC_WIDTH-1:0] restore_pc;

    assign fetching = (state == ST_FETCH_LO) || (state == ST_FETCH_HI);

    // Bus-side outputs decode straight from state so they are already low in
    // the first cycle after Reset or after the fetch ends.
    assign MemRead = fetching;
    assign MemAddr = fetching ? pc : '0;
    assign Busy    = fetching;
    assign Done    = (state == ST_DONE);
    assign PCOut   = pc;
    assign IRData  = ir_data;
    assign IRWrite = ir_write;
    assign IRLH    = ir_lh;

`ifdef FETCH_TIMEOUT_EN
    logic [PC_WIDTH-1:0] start_pc;
    logic                error_q;

    // Count restarts whenever we are not waiting in a fetch state, which
    // includes the byte-accept cycle, so it is zero on entry to either half.
    fetch_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .Clear   (!fetching || MemReady),
        .Waiting (fetching && !MemReady),
        .Expired (timeout_hit)
    );

    // Snapshot of the PC at Start; a timed-out fetch rolls back to it even
    // if the low byte had already advanced the PC.
    always_ff @(posedge Clock) begin
        if (Reset)
            start_pc <= '0;
        else if (state == ST_IDLE && Start && !PCLoad)
            start_pc <= pc;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            error_q <= 1'b0;
        else
            error_q <= timeout_hit;
    end

    assign restore_pc = start_pc;
    assign Error      = error_q;
`else
    assign timeout_hit = 1'b0;
    assign restore_pc  = pc;
    assign Error       = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir_data  <= '0;
            ir_write <= 1'b0;
            ir_lh    <= 1'b0;
        end else begin
            ir_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (PCLoad)
                        pc <= PCIn;
                    else if (Start)
                        state <= ST_FETCH_LO;
                end
                ST_FETCH_LO, ST_FETCH_HI: begin
                    if (MemReady) begin
                        ir_data  <= MemData;
                        ir_write <= 1'b1;
                        ir_lh    <= (state == ST_FETCH_HI);
                        pc       <= pc + 1'b1;
                        state    <= (state == ST_FETCH_HI) ? ST_DONE : ST_FETCH_HI;
                    end else if (timeout_hit) begin
                        pc    <= restore_pc;
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_sequencer
// Directed bench for instruction_fetch_sequencer with default parameters
// (PC_WIDTH=16, TIMEOUT=15). Memory is a small combinational lookup.
// The timeout scenario follows FETCH_TIMEOUT_EN like the design.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        PCLoad;
    logic [15:0] PCIn;
    logic [7:0]  MemData;
    logic        MemReady;
    logic        MemRead;
    logic [15:0] MemAddr;
    logic [7:0]  IRData;
    logic        IRWrite;
    logic        IRLH;
    logic [15:0] PCOut;
    logic        Busy;
    logic        Done;
    logic        Error;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    instruction_fetch_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .PCLoad   (PCLoad),
        .PCIn     (PCIn),
        .MemData  (MemData),
        .MemReady (MemReady),
        .MemRead  (MemRead),
        .MemAddr  (MemAddr),
        .IRData   (IRData),
        .IRWrite  (IRWrite),
        .IRLH     (IRLH),
        .PCOut    (PCOut),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error)
    );

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0010: mem_byte = 8'h34;
            16'h0011: mem_byte = 8'h12;
            16'hFFFF: mem_byte = 8'hAB;
            16'h0000: mem_byte = 8'hCD;
            default:  mem_byte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign MemData = mem_byte(MemAddr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] v);
        PCLoad = 1'b1;
        PCIn   = v;
        tick();
        PCLoad = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".MemRead"}, MemRead, 1'b0);
        check({tag, ".MemAddr"}, MemAddr, 16'h0000);
        check({tag, ".IRData"},  IRData,  8'h00);
        check({tag, ".IRWrite"}, IRWrite, 1'b0);
        check({tag, ".IRLH"},    IRLH,    1'b0);
        check({tag, ".Busy"},    Busy,    1'b0);
        check({tag, ".Done"},    Done,    1'b0);
        check({tag, ".Error"},   Error,   1'b0);
        check({tag, ".PCOut"},   PCOut,   16'h0000);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; PCLoad = 1'b0; PCIn = '0; MemReady = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        Reset = 1'b0;

        // Basic fetch from 0x0010 with MemReady held high
        load_pc(16'h0010);
        check("t1.pcload", PCOut, 16'h0010);
        check("t1.busy_idle", Busy, 1'b0);
        MemReady = 1'b1;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t1.lo.memread", MemRead, 1'b1);
        check("t1.lo.busy", Busy, 1'b1);
        check("t1.lo.addr", MemAddr, 16'h0010);
        check("t1.lo.irwrite", IRWrite, 1'b0);
        check("t1.lo.done", Done, 1'b0);
        tick();
        check("t1.hi.addr", MemAddr, 16'h0011);
        check("t1.s1.irwrite", IRWrite, 1'b1);
        check("t1.s1.irlh", IRLH, 1'b0);
        check("t1.s1.irdata", IRData, 8'h34);
        check("t1.hi.done", Done, 1'b0);
        tick();
        check("t1.s2.irwrite", IRWrite, 1'b1);
        check("t1.s2.irlh", IRLH, 1'b1);
        check("t1.s2.irdata", IRData, 8'h12);
        check("t1.done", Done, 1'b1);
        check("t1.done.busy", Busy, 1'b0);
        check("t1.done.memread", MemRead, 1'b0);
        check("t1.pcout", PCOut, 16'h0012);
        tick();
        check("t1.after.done", Done, 1'b0);
        check("t1.after.irwrite", IRWrite, 1'b0);

        // Wrap from 0xFFFF; PCLoad during the fetch must be ignored
        load_pc(16'hFFFF);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t2.lo.addr", MemAddr, 16'hFFFF);
        PCLoad = 1'b1;
        PCIn   = 16'h1234;
        tick();
        PCLoad = 1'b0;
        check("t2.hi.addr", MemAddr, 16'h0000);
        check("t2.s1.irdata", IRData, 8'hAB);
        tick();
        check("t2.s2.irdata", IRData, 8'hCD);
        check("t2.s2.irlh", IRLH, 1'b1);
        check("t2.pcout", PCOut, 16'h0001);
        tick();

        // PCLoad and Start together: load only
        PCLoad = 1'b1;
        Start  = 1'b1;
        PCIn   = 16'h0040;
        tick();
        PCLoad = 1'b0;
        Start  = 1'b0;
        check("t3.pcout", PCOut, 16'h0040);
        check("t3.busy0", Busy, 1'b0);
        tick();
        check("t3.busy1", Busy, 1'b0);
        check("t3.memread", MemRead, 1'b0);
        check("t3.irwrite", IRWrite, 1'b0);

        // Reset during FETCH_HI aborts with no high-byte strobe
        load_pc(16'h0030);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        check("t4.hi.addr", MemAddr, 16'h0031);
        check("t4.s1.irwrite", IRWrite, 1'b1);
        Reset = 1'b1;
        tick();
        check_idle_outputs("t4.reset");
        Reset = 1'b0;
        tick();
        check("t4.post.irwrite", IRWrite, 1'b0);
        check("t4.post.busy", Busy, 1'b0);

        // Memory never ready
        load_pc(16'h0020);
        MemReady = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i < 15; i++) begin
            check("t5.wait.error", Error, 1'b0);
            check("t5.wait.irwrite", IRWrite, 1'b0);
            check("t5.wait.busy", Busy, 1'b1);
            tick();
        end
        check("t5.pre.error", Error, 1'b0);
        tick();
        check("t5.error", Error, 1'b1);
        check("t5.busy", Busy, 1'b0);
        check("t5.irwrite", IRWrite, 1'b0);
        check("t5.pcout", PCOut, 16'h0020);
        tick();
        check("t5.error.pulse", Error, 1'b0);
        check("t5.idle.memread", MemRead, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            check("t5.wait.error", Error, 1'b0);
            check("t5.wait.busy", Busy, 1'b1);
            check("t5.wait.irwrite", IRWrite, 1'b0);
            tick();
        end
        check("t5.addr", MemAddr, 16'h0020);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t5.reset.busy", Busy, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_sequencer.md
INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of Clock.
REQ-002 Parameter PC_WIDTH, default 16, SHALL set the program-counter and memory-address width.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the memory-wait limit in cycles.
REQ-004 Clock  input  1  system clock.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 Start  input  1  request one 16-bit instruction fetch.
REQ-007 PCLoad  input  1  load the PC from PCIn.
REQ-008 PCIn  input  PC_WIDTH  new PC value.
REQ-009 MemData  input  8  byte returned by memory.
REQ-010 MemReady  input  1  MemData valid this cycle.
REQ-011 MemRead  output  1  memory read request.
REQ-012 MemAddr  output  PC_WIDTH  read address.
REQ-013 IRData  output  8  byte for the instruction register's I port.
REQ-014 IRWrite  output  1  instruction-register write strobe.
REQ-015 IRLH  output  1  half select: 0 = low byte [7:0], 1 = high byte [15:8].
REQ-016 PCOut  output  PC_WIDTH  current PC.
REQ-017 Busy  output  1  fetch in progress.
REQ-018 Done  output  1  one-cycle fetch-complete pulse.
REQ-019 Error  output  1  one-cycle timeout pulse.

Function
REQ-020 The FSM SHALL have the states IDLE, FETCH_LO, FETCH_HI and DONE.
- REQ-021 IDLE: a Start pulse moves the FSM to FETCH_LO on the next edge.
- REQ-022 IDLE: PCLoad=1 loads PC<=PCIn; PCLoad has priority over Start in the same cycle, so Start is ignored that cycle.
REQ-023 In FETCH_LO and FETCH_HI, MemRead=1, MemAddr=PC and Busy=1.
REQ-024 FETCH_LO with MemReady=1 SHALL act on the next edge:
- IRData<=MemData, IRWrite<=1 for one cycle, IRLH<=0;
- PC<=PC+1;
- state<=FETCH_HI.
REQ-025 FETCH_HI with MemReady=1 SHALL act identically, except IRLH<=1 and state<=DONE.
REQ-026 DONE SHALL assert Done=1 for exactly one cycle and return to IDLE; Busy=0 in DONE.
REQ-027 Start and PCLoad SHALL be ignored outside IDLE.
REQ-028 The PC SHALL increment modulo 2^PC_WIDTH (0xFFFF+1 = 0x0000); the high byte of a fetch from 0xFFFF SHALL come from address 0x0000.
REQ-029 The minimum fetch latency SHALL be 4 cycles from Start to Done with MemReady held high.
REQ-030 IRWrite SHALL be 0 in every cycle other than the two byte-strobe cycles.

Reset
REQ-031 Reset SHALL force state=IDLE and PC=0, and clear MemRead, MemAddr, IRData, IRWrite, IRLH, Busy, Done and Error to 0.
REQ-032 Reset asserted mid-fetch SHALL abort the fetch with no further IRWrite strobe.
REQ-033 Reset SHALL take priority over all other inputs.

Configuration
REQ-034 With FETCH_TIMEOUT_EN defined, a wait counter SHALL clear on entry to FETCH_LO or FETCH_HI.
- REQ-035 The counter increments each cycle the FSM waits with MemReady=0.
- REQ-036 When the count reaches TIMEOUT, the FSM returns to IDLE, Error pulses for one cycle, and PC is restored to its value at Start.
REQ-037 Without FETCH_TIMEOUT_EN, the FSM SHALL wait indefinitely for MemReady and Error SHALL be tied to 0.

Structure
REQ-038 Shared package fetch_pkg SHALL hold the state enumeration, the PC_WIDTH default and the TIMEOUT default.
REQ-039 The wait counter SHALL be a sub-module, fetch_watchdog, instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- REQ-041 PC=0x0010, MemReady=1 always, memory [0x10]=0x34, [0x11]=0x12 -> IRWrite strobes (IRLH=0, 0x34) then (IRLH=1, 0x12); Done 4 cycles after Start; PCOut=0x0012.
- REQ-042 PCLoad=1 with PCIn=0xFFFF, then Start -> MemAddr 0xFFFF then 0x0000; PCOut=0x0001.
- REQ-043 PCLoad and Start asserted together in IDLE -> PC loaded, no fetch started, Busy stays 0.
- REQ-044 Reset asserted in FETCH_HI -> next cycle all outputs 0, PC=0, no high-byte strobe.
- REQ-045 With FETCH_TIMEOUT_EN, TIMEOUT=15, PC=0x0020, MemReady held 0 -> Error pulse after 15 wait cycles, FSM in IDLE, PCOut=0x0020, IRWrite never asserted.
